// File: rtl/ov7670_capture_pkg.sv
// OV7670 capture shared types and constants.
// State encoding, frame marker word and pixel width.
package ov7670_capture_pkg;

  localparam int PIXEL_W = 16;
  localparam logic [16:0] FRAME_MARKER = 17'h10000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VS_END,
    WAIT_LINE,
    ACTIVE,
    DROP,
    END_FRAME
  } cap_state_t;

endpackage

// File: rtl/cam_edge_detect.sv
// Input register plus previous-value flop for edge detection.
// Ports: clk, reset_n, d (raw), q (registered), rise, fall.
module cam_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q    <= 1'b0;
      prev <= 1'b0;
    end else begin
      q    <= d;
      prev <= q;
    end
  end

  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 RGB565 byte stream to 17-bit FIFO words with frame marker.
// Ports: clk, reset_n, enable, cam_vsync/href/data, fifo_full,
// fifo_wr_en/data, frame_done, frame_err, overflow, clear_err,
// frame_count.
module ov7670_pixel_capture
  import ov7670_capture_pkg::*;
#(
  parameter int FRAME_WIDTH       = 640,
  parameter int FRAME_HEIGHT      = 480,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [16:0] fifo_data,
  output logic        frame_done,
  output logic        frame_err,
  output logic        overflow,
  input  logic        clear_err,
  output logic [15:0] frame_count
);

  localparam logic [15:0] W16 = 16'(FRAME_WIDTH);
  localparam logic [15:0] H16 = 16'(FRAME_HEIGHT);
  localparam int BYTE_W = PIXEL_W / 2;

  cap_state_t        state;
  logic [BYTE_W-1:0] d_q;
  logic [BYTE_W-1:0] hi;
  logic [15:0]       col;
  logic [15:0]       row;
  logic              phase;
  logic              line_long;

  logic vs_in, vs_act, vs_rise, vs_fall;
  logic hr_q, hr_rise, hr_fall;

  // Normalise polarity so the vsync flop holds "vsync active".
  assign vs_in = VSYNC_ACTIVE_HIGH ? cam_vsync : ~cam_vsync;

  cam_edge_detect u_vs (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (vs_in),
    .q       (vs_act),
    .rise    (vs_rise),
    .fall    (vs_fall)
  );

  cam_edge_detect u_hr (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (cam_href),
    .q       (hr_q),
    .rise    (hr_rise),
    .fall    (hr_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q <= '0;
    end else begin
      d_q <= cam_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      hi          <= '0;
      col         <= '0;
      row         <= '0;
      phase       <= 1'b0;
      line_long   <= 1'b0;
      fifo_wr_en  <= 1'b0;
      fifo_data   <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      fifo_wr_en <= 1'b0;
      frame_done <= 1'b0;
      // Later set statements override this clear.
      if (clear_err) begin
        frame_err <= 1'b0;
        overflow  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (vs_act) state <= WAIT_VS_END;
        end
        WAIT_VS_END: begin
          if (vs_fall) begin
            if (!enable) begin
              state <= IDLE;
            end else if (fifo_full) begin
              overflow <= 1'b1;
              state    <= DROP;
            end else begin
              fifo_wr_en <= 1'b1;
              fifo_data  <= FRAME_MARKER;
              row        <= '0;
              col        <= '0;
              phase      <= 1'b0;
              line_long  <= 1'b0;
              state      <= WAIT_LINE;
            end
          end
        end
        WAIT_LINE: begin
          if (vs_rise) begin
            // Frame result is registered on entry to END_FRAME.
            if (row == H16) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= END_FRAME;
          end else if (hr_rise) begin
            // First high byte arrives with the rising edge.
            hi        <= d_q;
            phase     <= 1'b1;
            col       <= '0;
            line_long <= 1'b0;
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            frame_err <= 1'b1;
            if (row == H16) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end
            state <= END_FRAME;
          end else if (hr_fall) begin
            if (col != W16 || phase || line_long) begin
              frame_err <= 1'b1;
            end else if (row != H16) begin
              row <= row + 16'd1;
            end
            col       <= '0;
            phase     <= 1'b0;
            line_long <= 1'b0;
            state     <= WAIT_LINE;
          end else if (hr_q) begin
            phase <= ~phase;
            if (!phase) begin
              hi <= d_q;
            end else begin
              if (col == W16) line_long <= 1'b1;
              else col <= col + 16'd1;
              if (col < W16 && row < H16) begin
                if (fifo_full) begin
                  overflow <= 1'b1;
                  state    <= DROP;
                end else begin
                  fifo_wr_en <= 1'b1;
                  fifo_data  <= {1'b0, hi, d_q};
                end
              end
            end
          end
        end
        DROP: begin
          if (vs_rise) state <= IDLE;
        end
        END_FRAME: begin
          state <= WAIT_VS_END;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
